// File: rtl/tri_pkg.sv
`default_nettype none
// ============================================================================
// tri_pkg : shared constants for the triangle job arbiter
// Rev 1.0 : initial release
// ============================================================================
package tri_pkg;

   localparam int VTX_W = 3;
   localparam int TRI_W = 6 * VTX_W;

   // Triangle packing {y2,x2,y1,x1,y0,x0}
   localparam int OFF_X0 = 0;
   localparam int OFF_Y0 = 3;
   localparam int OFF_X1 = 6;
   localparam int OFF_Y1 = 9;
   localparam int OFF_X2 = 12;
   localparam int OFF_Y2 = 15;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_SEND0     = 3'd1;
   localparam state_t ST_SEND1     = 3'd2;
   localparam state_t ST_SEND2     = 3'd3;
   localparam state_t ST_WAIT_BUSY = 3'd4;
   localparam state_t ST_RUN       = 3'd5;
   localparam state_t ST_DONE      = 3'd6;

   // Returns {y,x} of vertex k
   function automatic logic [2*VTX_W-1:0] tri_vertex(input logic [TRI_W-1:0] t_vec,
                                                      input logic [1:0]       k);
      case (k)
         2'd0:    return {t_vec[OFF_Y0 +: VTX_W], t_vec[OFF_X0 +: VTX_W]};
         2'd1:    return {t_vec[OFF_Y1 +: VTX_W], t_vec[OFF_X1 +: VTX_W]};
         default: return {t_vec[OFF_Y2 +: VTX_W], t_vec[OFF_X2 +: VTX_W]};
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/tri_rr_arb2.sv
`default_nettype none
// ============================================================================
// tri_rr_arb2 : two-way round-robin grant with pointer update on advance
// Rev 1.0 : initial release
// ============================================================================
module tri_rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic       gnt_valid_o,
   output logic       gnt_id_o
);

   logic rr_q;
   logic rr_d;

   assign gnt_valid_o = |req_i;
   assign gnt_id_o    = req_i[rr_q] ? rr_q : ~rr_q;

   // The loser of this grant becomes the preferred requester next time
   always_comb begin
      rr_d = rr_q;
      if (adv_i && gnt_valid_o) begin
         rr_d = ~gnt_id_o;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tri_job_arbiter.sv
`default_nettype none
// ============================================================================
// tri_job_arbiter : schedules two requesters' triangles onto one rasterizer
// Rev 1.0 : initial release
// ============================================================================
module tri_job_arbiter
   import tri_pkg::*;
#(
   parameter int WAIT_LIMIT = 4,
   parameter int RUN_LIMIT  = 255,
   parameter int CNT_W      = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   input  logic [35:0]       req_tri,
   output logic [1:0]        req_ready,
   output logic              rs_nt,
   output logic [2:0]        rs_xi,
   output logic [2:0]        rs_yi,
   input  logic              rs_busy,
   input  logic              rs_po,
   input  logic [2:0]        rs_xo,
   input  logic [2:0]        rs_yo,
   output logic              pix_valid,
   output logic [2:0]        pix_x,
   output logic [2:0]        pix_y,
   output logic              pix_id,
   output logic              done,
   output logic              done_id,
   output logic [CNT_W-1:0]  done_count,
   output logic              done_err,
   output logic              idle
);

   localparam int TMR_MAX = (RUN_LIMIT > WAIT_LIMIT) ? RUN_LIMIT : WAIT_LIMIT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   state_t               state_q, state_d;
   logic                 gid_q, gid_d;
   logic [1:0]           full_q, full_d;
   logic [TRI_W-1:0]     slot_q [0:1];
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 pix_valid_q;
   logic [2:0]           pix_x_q, pix_y_q;
   logic                 pix_id_q;

   logic                 w_arb_valid;
   logic                 w_arb_id;
   logic                 w_grant;
   logic                 w_pix_ok;
   logic [1:0]           w_load;
   logic                 w_send;
   logic [1:0]           w_vidx;
   logic [2*VTX_W-1:0]   w_vtx;

   tri_rr_arb2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req_i       (full_q),
      .adv_i       (w_grant),
      .gnt_valid_o (w_arb_valid),
      .gnt_id_o    (w_arb_id)
   );

   assign w_grant  = (state_q == ST_IDLE) && w_arb_valid;
   assign w_pix_ok = rs_po && ((state_q == ST_WAIT_BUSY) || (state_q == ST_RUN));
   assign w_load   = req_valid & ~full_q;

   // A slot frees after its last vertex so the next job can queue during RUN
   always_comb begin
      full_d = full_q | w_load;
      if (state_q == ST_SEND2) begin
         full_d[gid_q] = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      tmr_d   = tmr_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (w_arb_valid) begin
               state_d = ST_SEND0;
               gid_d   = w_arb_id;
               tmr_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_SEND0: state_d = ST_SEND1;
         ST_SEND1: state_d = ST_SEND2;
         ST_SEND2: begin
            state_d = ST_WAIT_BUSY;
            tmr_d   = '0;
         end
         ST_WAIT_BUSY: begin
            if (rs_busy) begin
               state_d = ST_RUN;
               tmr_d   = '0;
            end else if (tmr_q == TMR_W'(WAIT_LIMIT - 1)) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!rs_busy) begin
               state_d = ST_DONE;
            end else if (tmr_q == TMR_W'(RUN_LIMIT - 1)) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (w_grant) begin
         cnt_d = '0;
      end else if (w_pix_ok && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         gid_q       <= 1'b0;
         full_q      <= 2'b00;
         tmr_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_id_q    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         gid_q       <= gid_d;
         full_q      <= full_d;
         tmr_q       <= tmr_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         pix_valid_q <= w_pix_ok;
         if (w_pix_ok) begin
            pix_x_q  <= rs_xo;
            pix_y_q  <= rs_yo;
            pix_id_q <= gid_q;
         end
         for (int i = 0; i < 2; i++) begin
            if (w_load[i]) begin
               slot_q[i] <= req_tri[TRI_W*i +: TRI_W];
            end
         end
      end
   end

   assign w_send = (state_q == ST_SEND0) || (state_q == ST_SEND1) || (state_q == ST_SEND2);
   assign w_vidx = (state_q == ST_SEND1) ? 2'd1 :
                   (state_q == ST_SEND2) ? 2'd2 : 2'd0;
   assign w_vtx  = tri_vertex(slot_q[gid_q], w_vidx);

   assign rs_nt      = (state_q == ST_SEND0);
   assign rs_xi      = w_send ? w_vtx[VTX_W-1:0]       : 3'd0;
   assign rs_yi      = w_send ? w_vtx[2*VTX_W-1:VTX_W] : 3'd0;
   assign req_ready  = ~full_q;
   assign pix_valid  = pix_valid_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign pix_id     = pix_id_q;
   assign done       = (state_q == ST_DONE);
   assign done_id    = done & gid_q;
   assign done_count = done ? cnt_q : '0;
   assign done_err   = done & err_q;
   assign idle       = (state_q == ST_IDLE) && (full_q == 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_tri_job_arbiter.sv
`default_nettype none
// ============================================================================
// tb_tri_job_arbiter : directed self-checking bench with a rasterizer model
// Rev 1.0 : initial release
// ============================================================================
module tb_tri_job_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [35:0] req_tri;
   logic [1:0]  req_ready;
   logic        rs_nt;
   logic [2:0]  rs_xi, rs_yi;
   logic        rs_busy, rs_po;
   logic [2:0]  rs_xo, rs_yo;
   logic        pix_valid;
   logic [2:0]  pix_x, pix_y;
   logic        pix_id;
   logic        done, done_id, done_err, idle;
   logic [6:0]  done_count;

   int total = 0;
   int bad   = 0;

   // Rasterizer model: busy for 6 cycles starting 1 cycle after SEND2,
   // then one tail cycle; the first po_n cycles of those 7 emit a pixel
   logic       busy_en;
   int         po_n;
   logic       t_po;
   logic [2:0] t_xo, t_yo;
   logic       m_busy, m_po;
   logic [2:0] m_xo, m_yo;
   int         m_ph, m_win, m_idx, m_w;

   assign m_w     = (m_ph == 2 && busy_en) ? 7 : ((m_win > 0) ? m_win - 1 : 0);
   assign rs_busy = m_busy;
   assign rs_po   = m_po | t_po;
   assign rs_xo   = t_po ? t_xo : m_xo;
   assign rs_yo   = t_po ? t_yo : m_yo;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0; m_po <= 1'b0; m_xo <= 3'd0; m_yo <= 3'd0;
         m_ph <= 0; m_win <= 0; m_idx <= 0;
      end else begin
         m_win  <= m_w;
         m_busy <= (m_w >= 2);
         m_po   <= 1'b0;
         if (rs_nt) begin
            m_ph <= 1; m_idx <= 0;
         end else if (m_ph == 1) begin
            m_ph <= 2;
         end else begin
            m_ph <= 0;
         end
         if (m_w > 0 && m_idx < po_n) begin
            m_po  <= 1'b1;
            m_xo  <= 3'(m_idx);
            m_yo  <= 3'(m_idx + 1);
            m_idx <= m_idx + 1;
         end
      end
   end

   logic [6:0] pq [$];
   int         done_seen = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (pix_valid) pq.push_back({pix_id, pix_y, pix_x});
         if (done) done_seen++;
      end
   end

   tri_job_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_tri    (req_tri),
      .req_ready  (req_ready),
      .rs_nt      (rs_nt),
      .rs_xi      (rs_xi),
      .rs_yi      (rs_yi),
      .rs_busy    (rs_busy),
      .rs_po      (rs_po),
      .rs_xo      (rs_xo),
      .rs_yo      (rs_yo),
      .pix_valid  (pix_valid),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_id     (pix_id),
      .done       (done),
      .done_id    (done_id),
      .done_count (done_count),
      .done_err   (done_err),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (done !== 1'b1 && n < budget);
      chk("done_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (rs_busy !== 1'b1 && n < 12);
      chk("busy_rise", {31'd0, rs_busy}, 32'd1);
   endtask

   function automatic logic [17:0] mk(input int x0, y0, x1, y1, x2, y2);
      return {3'(y2), 3'(x2), 3'(y1), 3'(x1), 3'(y0), 3'(x0)};
   endfunction

   initial begin
      int snap;
      reset = 1'b1; req_valid = 2'b00; req_tri = '0;
      busy_en = 1'b1; po_n = 0; t_po = 1'b0; t_xo = 3'd0; t_yo = 3'd0;
      step();
      step();
      reset = 1'b0;

      chk("rst_ready", 32'(req_ready), 32'h3);
      chk("rst_idle",  32'(idle), 32'h1);
      chk("rst_nt",    32'(rs_nt), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_pixv",  32'(pix_valid), 32'h0);
      chk("rst_cnt",   32'(done_count), 32'h0);

      // Single job from requester 0
      po_n = 5;
      req_tri[17:0] = mk(1, 1, 3, 1, 1, 3);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      pq.delete();
      chk("load_ready", 32'(req_ready), 32'h2);
      chk("load_idle",  32'(idle), 32'h0);
      chk("load_nt",    32'(rs_nt), 32'h0);
      step();
      chk("s0_nt",  32'(rs_nt), 32'h1);
      chk("s0_vtx", 32'({rs_yi, rs_xi}), 32'({3'd1, 3'd1}));
      step();
      chk("s1_nt",  32'(rs_nt), 32'h0);
      chk("s1_vtx", 32'({rs_yi, rs_xi}), 32'({3'd1, 3'd3}));
      step();
      chk("s2_vtx",   32'({rs_yi, rs_xi}), 32'({3'd3, 3'd1}));
      chk("s2_ready", 32'(req_ready), 32'h2);
      step();
      chk("wb_ready", 32'(req_ready), 32'h3);
      chk("wb_vtx",   32'({rs_yi, rs_xi}), 32'h0);
      run_to_done(30);
      chk("j1_id",   32'(done_id), 32'h0);
      chk("j1_cnt",  32'(done_count), 32'd5);
      chk("j1_err",  32'(done_err), 32'h0);
      chk("j1_npix", 32'(pq.size()), 32'd5);
      if (pq.size() == 5) begin
         chk("j1_pix0", 32'(pq[0]), 32'({1'b0, 3'd1, 3'd0}));
         chk("j1_pix4", 32'(pq[4]), 32'({1'b0, 3'd5, 3'd4}));
      end
      step();
      chk("j1_idle", 32'(idle), 32'h1);

      // Contention: both requesters offer together, twice
      do_reset();
      po_n = 7;
      req_tri = {mk(2, 2, 4, 2, 2, 4), mk(5, 5, 6, 5, 5, 6)};
      for (int r = 0; r < 2; r++) begin
         req_valid = 2'b11;
         step();
         req_valid = 2'b00;
         chk("ct_ready", 32'(req_ready), 32'h0);
         run_to_done(40);
         chk("ct_id_a",  32'(done_id), 32'h0);
         chk("ct_cnt_a", 32'(done_count), 32'd7);
         run_to_done(40);
         chk("ct_id_b",  32'(done_id), 32'h1);
         chk("ct_cnt_b", 32'(done_count), 32'd7);
         step();
      end

      // Back-to-back from requester 1
      do_reset();
      po_n = 2;
      req_tri[35:18] = mk(7, 0, 0, 7, 7, 7);
      req_valid = 2'b10;
      step();
      req_valid = 2'b00;
      wait_busy();
      step();
      chk("bb_ready_run", 32'(req_ready), 32'h3);
      req_tri[35:18] = mk(2, 6, 6, 2, 4, 4);
      req_valid = 2'b10;
      step();
      req_valid = 2'b00;
      chk("bb_ready_q", 32'(req_ready), 32'h1);
      run_to_done(20);
      chk("bb_id1", 32'(done_id), 32'h1);
      step();
      chk("bb_nt_idle", 32'(rs_nt), 32'h0);
      step();
      chk("bb_nt", 32'(rs_nt), 32'h1);
      chk("bb_vtx0", 32'({rs_yi, rs_xi}), 32'({3'd6, 3'd2}));
      run_to_done(20);
      chk("bb_id2",  32'(done_id), 32'h1);
      chk("bb_cnt2", 32'(done_count), 32'd2);
      step();

      // Busy timeout
      busy_en = 1'b0;
      req_tri[17:0] = mk(0, 0, 1, 0, 0, 1);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      chk("to_nt", 32'(rs_nt), 32'h1);
      step();
      step();
      step();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("to_early", 32'(done), 32'h0);
      end
      step();
      chk("to_done", 32'(done), 32'h1);
      chk("to_err",  32'(done_err), 32'h1);
      chk("to_cnt",  32'(done_count), 32'h0);
      step();
      chk("to_idle", 32'(idle), 32'h1);
      busy_en = 1'b1;

      // Reset in RUN after two pixels
      po_n = 5;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      wait_busy();
      step();
      step();
      snap = done_seen;
      #2;
      reset = 1'b1;
      #1;
      chk("rr_ready", 32'(req_ready), 32'h3);
      chk("rr_idle",  32'(idle), 32'h1);
      chk("rr_nt",    32'(rs_nt), 32'h0);
      chk("rr_pixv",  32'(pix_valid), 32'h0);
      step();
      reset = 1'b0;
      repeat (10) step();
      chk("rr_nodone", 32'(done_seen), 32'(snap));
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      run_to_done(30);
      chk("rr_fresh_cnt", 32'(done_count), 32'd5);
      chk("rr_fresh_err", 32'(done_err), 32'h0);
      step();

      // Stray pixel while idle
      t_po = 1'b1; t_xo = 3'd6; t_yo = 3'd6;
      step();
      t_po = 1'b0;
      chk("st_pixv0", 32'(pix_valid), 32'h0);
      step();
      chk("st_pixv1", 32'(pix_valid), 32'h0);
      po_n = 3;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      run_to_done(30);
      chk("st_cnt", 32'(done_count), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
